// File: rtl/xadc_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// xadc_pkg: shared XADC DRP addresses, code width, FSM encoding and helpers.
// Rev 1.0
// ----------------------------------------------------------------------------
package xadc_pkg;

  localparam int         CODE_W        = 12;
  localparam int         MAX_AVG_SHIFT = 3;
  localparam logic [6:0] AUX0_ADDR     = 7'h10;
  localparam logic [6:0] STATUS_ADDR   = 7'h3F;
  localparam logic [6:0] CONFIG0_ADDR  = 7'h40;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESULT = 2'd3
  } state_e;

  // Summing 2^max_shift codes needs max_shift extra bits of headroom.
  function automatic int acc_width(input int code_w, input int max_shift);
    return code_w + max_shift;
  endfunction

endpackage
`default_nettype wire

// File: rtl/xadc_argmax.sv
`default_nettype none
// ----------------------------------------------------------------------------
// xadc_argmax: thresholded winner-take-all over NUM_CHANNELS averaged codes.
// Rev 1.0
// ----------------------------------------------------------------------------
module xadc_argmax
  import xadc_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int CH_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic [NUM_CHANNELS-1:0][CODE_W-1:0] avg_i,
  input  logic [CODE_W-1:0]                   threshold_i,
  output logic [CH_W-1:0]                     winner_o,
  output logic                                winner_valid_o,
  output logic [NUM_CHANNELS-1:0]             above_mask_o
);

  logic [CODE_W-1:0] best_w;

  for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_mask
    assign above_mask_o[k] = avg_i[k] > threshold_i;
  end

  // Strict '>' keeps the lowest index on ties.
  always_comb begin
    best_w         = '0;
    winner_o       = '0;
    winner_valid_o = 1'b0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (above_mask_o[k] && (!winner_valid_o || avg_i[k] > best_w)) begin
        best_w         = avg_i[k];
        winner_o       = CH_W'(k);
        winner_valid_o = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/xadc_channel_classifier.sv
`default_nettype none
// ----------------------------------------------------------------------------
// xadc_channel_classifier: DRP sweep of aux channels, averaging, thresholding.
// Rev 1.0
// ----------------------------------------------------------------------------
module xadc_channel_classifier
  import xadc_pkg::*;
#(
  parameter int         NUM_CHANNELS   = 4,
  parameter logic [6:0] BASE_ADDR      = AUX0_ADDR,
  parameter int         TIMEOUT_CYCLES = 64,
  parameter int         CH_W           = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                    S_AXI_ACLK,
  input  logic                    S_AXI_ARESETN,
  input  logic                    enable,
  input  logic [CODE_W-1:0]       threshold,
  input  logic [1:0]              avg_sel,
  input  logic                    clear_err,
  input  logic                    eos,
  input  logic                    busy,
  input  logic                    drdy,
  input  logic [15:0]             do_data,
  output logic [6:0]              daddr,
  output logic                    den,
  output logic                    dwe,
  output logic [15:0]             di,
  output logic [CH_W-1:0]         winner,
  output logic                    winner_valid,
  output logic [NUM_CHANNELS-1:0] above_mask,
  output logic                    sample_valid,
  output logic                    timeout_err
);

  localparam int              ACC_W   = acc_width(CODE_W, MAX_AVG_SHIFT);
  localparam int              TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CHANNELS - 1);

  state_e                  state_q, state_d;
  logic [CH_W-1:0]         ch_q, ch_d;
  logic [3:0]              sweep_q, sweep_d;
  logic [1:0]              avg_sel_q, avg_sel_d;
  logic [TMO_W-1:0]        tmo_q, tmo_d;
  logic                    abort_q, abort_d;
  logic                    timeout_err_q, timeout_err_d;
  logic [ACC_W-1:0]        acc_q [NUM_CHANNELS];
  logic [ACC_W-1:0]        acc_d [NUM_CHANNELS];
  logic [CH_W-1:0]         winner_q;
  logic                    winner_valid_q;
  logic [NUM_CHANNELS-1:0] above_mask_q;
  logic                    sample_valid_q;

  logic                    discard_w;
  logic                    timeout_evt_w;
  logic [3:0]              sweep_inc_w;
  logic [NUM_CHANNELS-1:0][CODE_W-1:0] avg_w;
  logic [CH_W-1:0]         winner_w;
  logic                    winner_valid_w;
  logic [NUM_CHANNELS-1:0] above_mask_w;
  logic                    unused_ok;

  assign unused_ok = ^{busy, do_data[3:0]};

  for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_avg
    assign avg_w[k] = CODE_W'(acc_q[k] >> avg_sel_q);
  end

  xadc_argmax #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .CH_W         (CH_W)
  ) u_argmax (
    .avg_i          (avg_w),
    .threshold_i    (threshold),
    .winner_o       (winner_w),
    .winner_valid_o (winner_valid_w),
    .above_mask_o   (above_mask_w)
  );

  assign sweep_inc_w = sweep_q + 4'd1;

  always_comb begin
    state_d       = state_q;
    ch_d          = ch_q;
    sweep_d       = sweep_q;
    avg_sel_d     = avg_sel_q;
    tmo_d         = tmo_q;
    abort_d       = abort_q;
    acc_d         = acc_q;
    discard_w     = 1'b0;
    timeout_evt_w = 1'b0;

    case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        if (!enable) begin
          discard_w = 1'b1;
        end else if (eos) begin
          state_d = ST_ISSUE;
          if (sweep_q == 4'd0) avg_sel_d = avg_sel;
        end
      end
      ST_ISSUE: begin
        tmo_d = '0;
        if (!enable) begin
          discard_w = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // After enable drops the in-flight read is drained, then dropped.
        if (!enable) abort_d = 1'b1;
        if (drdy) begin
          if (abort_q || !enable) begin
            discard_w = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            acc_d[ch_q] = acc_q[ch_q] + ACC_W'(do_data[15:4]);
            if (ch_q == LAST_CH) begin
              ch_d    = '0;
              sweep_d = sweep_inc_w;
              state_d = (sweep_inc_w == (4'd1 << avg_sel_q)) ? ST_RESULT : ST_IDLE;
            end else begin
              ch_d    = ch_q + 1'b1;
              state_d = ST_ISSUE;
            end
          end
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_evt_w = 1'b1;
          discard_w     = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_RESULT: begin
        discard_w = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (discard_w) begin
      ch_d    = '0;
      sweep_d = '0;
      for (int k = 0; k < NUM_CHANNELS; k++) acc_d[k] = '0;
    end

    timeout_err_d = clear_err ? 1'b0 : (timeout_evt_w ? 1'b1 : timeout_err_q);
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q        <= ST_IDLE;
      ch_q           <= '0;
      sweep_q        <= '0;
      avg_sel_q      <= '0;
      tmo_q          <= '0;
      abort_q        <= 1'b0;
      timeout_err_q  <= 1'b0;
      winner_q       <= '0;
      winner_valid_q <= 1'b0;
      above_mask_q   <= '0;
      sample_valid_q <= 1'b0;
      for (int k = 0; k < NUM_CHANNELS; k++) acc_q[k] <= '0;
    end else begin
      state_q        <= state_d;
      ch_q           <= ch_d;
      sweep_q        <= sweep_d;
      avg_sel_q      <= avg_sel_d;
      tmo_q          <= tmo_d;
      abort_q        <= abort_d;
      timeout_err_q  <= timeout_err_d;
      acc_q          <= acc_d;
      sample_valid_q <= (state_q == ST_RESULT);
      if (state_q == ST_RESULT) begin
        winner_q       <= winner_w;
        winner_valid_q <= winner_valid_w;
        above_mask_q   <= above_mask_w;
      end
    end
  end

  assign daddr        = BASE_ADDR + 7'(ch_q);
  assign den          = (state_q == ST_ISSUE) && enable;
  assign dwe          = 1'b0;
  assign di           = 16'h0000;
  assign winner       = winner_q;
  assign winner_valid = winner_valid_q;
  assign above_mask   = above_mask_q;
  assign sample_valid = sample_valid_q;
  assign timeout_err  = timeout_err_q;

endmodule
`default_nettype wire

// File: doc/xadc_channel_classifier.md
Name: xadc_channel_classifier

Overview:
- Parametrised successor to the fixed 4-channel XADC reader that drives the network output.
- On each XADC end-of-sequence (EOS), reads NUM_CHANNELS auxiliary-channel result registers over the DRP port and optionally averages them over 1/2/4/8 sweeps.
- Thresholds each averaged value and reports a winner-take-all class index plus an above-threshold mask.
- Sits between the XADC primitive and the AXI config/status register block.

Parameters:
- NUM_CHANNELS, 4, aux channels read per sweep, 1..16.
- BASE_ADDR, 7'h10, DRP address of aux channel 0; channel k is read at BASE_ADDR+k.
- TIMEOUT_CYCLES, 64, maximum cycles to wait for DRDY after DEN.
- CH_W, $clog2(NUM_CHANNELS) (minimum 1), width of the winner index.

Ports:
- S_AXI_ACLK  in  1  sole clock, also the DRP DCLK.
- S_AXI_ARESETN  in  1  asynchronous active-low reset.
- enable  in  1  level; 1 allows sweeps to start.
- threshold  in  12  unsigned compare level applied to the averaged code.
- avg_sel  in  2  sweeps per result = 2^avg_sel.
- clear_err  in  1  one-cycle pulse; clears timeout_err.
- eos  in  1  XADC EOS pulse.
- busy  in  1  XADC BUSY; status only, not used for control.
- drdy  in  1  DRP data ready.
- do_data  in  16  DRP read data.
- daddr  out  7  DRP address.
- den  out  1  DRP enable, one-cycle pulse.
- dwe  out  1  DRP write enable, tied 0.
- di  out  16  DRP write data, tied 0.
- winner  out  CH_W  index of the largest above-threshold channel.
- winner_valid  out  1  1 if at least one channel is above threshold.
- above_mask  out  NUM_CHANNELS  bit k = avg[k] > threshold.
- sample_valid  out  1  one-cycle pulse when the result outputs update.
- timeout_err  out  1  sticky DRDY-timeout flag.

Behaviour:
- Reset: all outputs 0, daddr=BASE_ADDR, FSM in IDLE, accumulators, channel counter and sweep counter 0.
- States: IDLE, ISSUE, WAIT, RESULT.
- IDLE:
  - On eos=1 with enable=1, go to ISSUE.
  - Latch avg_sel only when the sweep counter is 0.
  - eos arriving in any other state is dropped.
- ISSUE:
  - den=1 for exactly this cycle; daddr=BASE_ADDR+ch.
  - Next state is WAIT; clear the timeout counter.
- WAIT:
  - On drdy, add do_data[15:4] to acc[ch]. Accumulators are 15 bits wide, so 8×4095 cannot overflow.
  - If ch is not the last channel: ch++ and go to ISSUE. Back-to-back: ISSUE follows the drdy cycle directly.
  - If ch is the last channel: ch=0, sweep++. If the sweep count now equals 2^avg_sel_latched, go to RESULT; otherwise go to IDLE to await the next eos.
- Timeout:
  - If drdy does not arrive within TIMEOUT_CYCLES cycles of den, set timeout_err.
  - Clear all accumulators, ch and sweep; go to IDLE. No sample_valid is produced.
- RESULT, a single cycle:
  - avg[k] = acc[k] >> avg_sel_latched, giving 12 bits.
  - above_mask, winner and winner_valid are registered from avg[] combinationally.
  - Argmax considers only above-threshold channels; on a tie the lowest index wins.
  - If none are above threshold: winner=0, winner_valid=0.
  - Accumulators and sweep are cleared; next state is IDLE.
- sample_valid is high the cycle after RESULT.
  - Latency: final drdy at cycle t gives RESULT at t+1 and outputs plus sample_valid at t+2.
  - Result outputs hold their values until the next RESULT.
- enable deasserted mid-sweep:
  - The outstanding DRP transaction completes; its data is discarded.
  - All partial accumulation is discarded and the FSM returns to IDLE. den is never issued while enable=0.
- Changing threshold between results affects only the next RESULT. Changing avg_sel mid-window has no effect until the next window.
- clear_err takes priority over a simultaneous new timeout: clear wins, and the flag re-sets on the next timeout.
- Asynchronous reset mid-transaction aborts immediately; a late drdy arriving in IDLE is ignored.
- The design holds for NUM_CHANNELS=1: CH_W=1 and winner is always 0.

Decomposition:
- Shared package xadc_pkg holds:
  - DRP address constants (AUX0_ADDR=7'h10, STATUS/CONFIG addresses),
  - the ADC code width (12),
  - the FSM state encoding,
  - the helper function for the accumulator width.
- One sub-module is natural: xadc_argmax. It is a combinational, parametrised NUM_CHANNELS×12-bit reduction that produces winner, winner_valid and above_mask, with lowest-index tie-break.

Test Plan:
1. NUM_CHANNELS=4, avg_sel=0, threshold=0x400, DRP model returns ch0..3 = 0x100,0x800,0x900,0x200 (codes in do_data[15:4]); one eos → four den pulses at daddr 0x10..0x13; then winner=2, winner_valid=1, above_mask=4'b0110, one sample_valid two cycles after the last drdy.
2. Tie case: ch1=ch3=0xA00, others 0x000, threshold=0x100 → winner=1, above_mask=4'b1010.
3. avg_sel=2, ch0 returns 0x800,0x800,0x400,0x400 over four eos; others 0 → exactly one sample_valid after the fourth sweep; avg ch0=0x600, winner=0; no sample_valid after sweeps 1–3.
4. All channels 0x0FF, threshold=0xFFF → winner_valid=0, winner=0, above_mask=0, sample_valid still pulses.
5. DRP model withholds drdy on ch2 → timeout_err=1 at TIMEOUT_CYCLES, no sample_valid, next eos restarts at daddr 0x10; clear_err pulse → timeout_err=0.
6. Drop enable while waiting for drdy on ch1 → no further den, no sample_valid; re-enable plus eos → clean sweep from ch0 with correct result; eos pulses during WAIT are ignored (den count stays 4 per sweep).
